// File: rtl/noc_credit_mux_if.sv
// rtl/noc_credit_mux_if.sv - flit/credit link bundle between N upstream channels and the shared output
interface noc_credit_mux_if #(
    parameter int NUM_CH     = 4,
    parameter int FLIT_WIDTH = 32
);
    localparam int GW = $clog2(NUM_CH);

    logic [NUM_CH-1:0]                 rx;
    logic [NUM_CH-1:0][FLIT_WIDTH-1:0] data_i;
    logic [NUM_CH-1:0]                 credit_o;
    logic                              tx;
    logic [FLIT_WIDTH-1:0]             data_o;
    logic                              credit_i;
    logic [GW-1:0]                     grant_o;
    logic                              busy_o;

    modport master (output rx, data_i, credit_i, input credit_o, tx, data_o, grant_o, busy_o);
    modport slave  (input rx, data_i, credit_i, output credit_o, tx, data_o, grant_o, busy_o);
endinterface

// File: rtl/noc_credit_mux.sv
// rtl/noc_credit_mux.sv - N-channel credit-based flit mux with per-channel FIFOs and packet-locked round-robin
module noc_credit_mux #(
    parameter int NUM_CH     = 4,
    parameter int FLIT_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int SIZE_BITS  = 16
) (
    input logic             clock,
    input logic             reset,
    noc_credit_mux_if.slave link
);
    localparam int GW = $clog2(NUM_CH);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, HDR, SIZE, PAYLOAD} state_t;

    state_t                state, state_next;
    logic [GW-1:0]         grant, grant_next, rr_ptr, rr_next, pick, grant_inc;
    logic                  found;
    logic [SIZE_BITS-1:0]  remain, remain_next;
    logic [FLIT_WIDTH-1:0] mem [NUM_CH][DEPTH];
    logic [AW-1:0]         wr_ptr [NUM_CH];
    logic [AW-1:0]         rd_ptr [NUM_CH];
    logic [CW-1:0]         count [NUM_CH];
    logic [NUM_CH-1:0]     nonempty, credit, push, pop;
    logic [FLIT_WIDTH-1:0] head;
    logic                  tx;
    int                    idx;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            nonempty[c] = (count[c] != '0);
            credit[c]   = (count[c] < CW'(DEPTH));
            push[c]     = link.rx[c] && credit[c];
            pop[c]      = tx && (grant == GW'(c));
        end
    end

    assign head      = mem[grant][rd_ptr[grant]];
    assign tx        = (state != IDLE) && link.credit_i && nonempty[grant];
    assign grant_inc = (grant == GW'(NUM_CH - 1)) ? '0 : grant + 1'b1;

    assign link.credit_o = credit;
    assign link.tx       = tx;
    assign link.data_o   = tx ? head : '0;
    assign link.grant_o  = grant;
    assign link.busy_o   = (state != IDLE);

    // First nonempty channel at or after rr_ptr, wrapping past NUM_CH-1.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!found && nonempty[idx]) begin
                found = 1'b1;
                pick  = GW'(idx);
            end
        end
    end

    always_comb begin
        state_next  = state;
        grant_next  = grant;
        rr_next     = rr_ptr;
        remain_next = remain;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_next = pick;
                    state_next = HDR;
                end
            end
            HDR: begin
                if (tx) state_next = SIZE;
            end
            SIZE: begin
                if (tx) begin
                    remain_next = head[SIZE_BITS-1:0];
                    if (head[SIZE_BITS-1:0] == '0) begin
                        state_next = IDLE;
                        rr_next    = grant_inc;
                    end else begin
                        state_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (tx) begin
                    remain_next = remain - 1'b1;
                    if (remain == SIZE_BITS'(1)) begin
                        state_next = IDLE;
                        rr_next    = grant_inc;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            remain <= '0;
        end else begin
            state  <= state_next;
            grant  <= grant_next;
            rr_ptr <= rr_next;
            remain <= remain_next;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
                if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
                if (push[c] && !pop[c])      count[c] <= count[c] + 1'b1;
                else if (!push[c] && pop[c]) count[c] <= count[c] - 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) mem[c][wr_ptr[c]] <= link.data_i[c];
        end
    end
endmodule
